cordic_sweep_sequencer: RTL

- Controller that sequences the shared CORDIC_sine core through one full sine period of N_SAMPLES points.
- It generates each angle with quadrant folding, issues the start pulse, waits for done, applies the sign and 0x80 offset, and emits one 8-bit sample per point.
- Sits between the frame-level start logic and the pixel-image builder, so the CORDIC core sees a single clean requester.

---
 rtl/cordic_pkg.sv | 19 +
 rtl/cordic_angle_gen.sv | 53 +++++
 rtl/cordic_sweep_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sweep sequencer and its angle generator.
package cordic_pkg;

    localparam int unsigned ANGLE_W = 16;
    localparam int unsigned SINE_W  = 8;

    localparam logic [SINE_W-1:0]  ZERO_OFFSET  = 8'h80;
    localparam logic [ANGLE_W-1:0] STEP_DEFAULT = 16'h0648;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StEmit,
        StDone,
        StError
    } seq_state_e;

endpackage

// File: rtl/cordic_angle_gen.sv
// Quadrant-folded angle accumulator: tracks j*STEP for the sample selected by (k, q)
// using only add/subtract, plus the sign that sample needs.
module cordic_angle_gen
    import cordic_pkg::*;
#(
    parameter int unsigned         K_W  = 4,
    parameter logic [ANGLE_W-1:0]  STEP = STEP_DEFAULT
) (
    input  logic               mclk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [K_W-1:0]     k,
    input  logic [1:0]         q,
    output logic [ANGLE_W-1:0] angle,
    output logic               sign
);

    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               sign_q, sign_d;
    logic               reload, rising;

    // Even quadrants restart at 0 and climb; odd quadrants peak at k=0 then descend.
    always_comb begin
        reload  = ~q[0] && (k == '0);
        rising  = ~q[0] || (k == '0);
        angle_d = angle_q;
        sign_d  = sign_q;
        if (load) begin
            sign_d = q[1];
            if (reload) begin
                angle_d = '0;
            end else if (rising) begin
                angle_d = angle_q + STEP;
            end else begin
                angle_d = angle_q - STEP;
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q <= '0;
            sign_q  <= 1'b0;
        end else begin
            angle_q <= angle_d;
            sign_q  <= sign_d;
        end
    end

    assign angle = angle_q;
    assign sign  = sign_q;

endmodule

// File: rtl/cordic_sweep_sequencer.sv
// Drives the shared CORDIC_sine core through one sine period and emits one
// offset-binary sample per point, with a watchdog on the core's done handshake.
module cordic_sweep_sequencer
    import cordic_pkg::*;
#(
    parameter int unsigned        N_SAMPLES = 64,
    parameter logic [ANGLE_W-1:0] STEP      = STEP_DEFAULT,
    parameter int unsigned        TIMEOUT   = 255
) (
    input  logic                         mclk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         cordic_start,
    output logic [ANGLE_W-1:0]           cordic_angle,
    input  logic                         cordic_done,
    input  logic [SINE_W-1:0]            cordic_sint,
    output logic                         sample_valid,
    output logic [$clog2(N_SAMPLES)-1:0] sample_idx,
    output logic [SINE_W-1:0]            sample_val,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         error
);

    localparam int unsigned IDX_W = $clog2(N_SAMPLES);
    localparam int unsigned SPQ   = N_SAMPLES / 4;
    localparam int unsigned K_W   = (SPQ > 1) ? $clog2(SPQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
    localparam logic [K_W-1:0]   LAST_K   = K_W'(SPQ - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  i_q, i_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [1:0]        q_q, q_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [SINE_W-1:0] sint_q, sint_d;
    logic              error_q, error_d;
    logic              gen_load;
    logic              sign;

    // Angle generator is advanced on the edge that enters ISSUE, so the angle and
    // sign already belong to sample i throughout ISSUE, WAIT and EMIT.
    cordic_angle_gen #(
        .K_W  (K_W),
        .STEP (STEP)
    ) u_angle_gen (
        .mclk  (mclk),
        .rst_n (rst_n),
        .load  (gen_load),
        .k     (k_d),
        .q     (q_d),
        .angle (cordic_angle),
        .sign  (sign)
    );

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        k_d      = k_q;
        q_d      = q_q;
        wd_d     = wd_q;
        sint_d   = sint_q;
        error_d  = error_q;
        gen_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StIssue;
                    i_d      = '0;
                    k_d      = '0;
                    q_d      = '0;
                    error_d  = 1'b0;
                    gen_load = 1'b1;
                end
            end
            StIssue: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                // Done is tested first so it wins over a same-cycle watchdog expiry.
                if (cordic_done) begin
                    sint_d  = cordic_sint;
                    state_d = StEmit;
                end else if (wd_q == WD_MAX) begin
                    error_d = 1'b1;
                    state_d = StError;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StEmit: begin
                if (i_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    i_d      = i_q + 1'b1;
                    gen_load = 1'b1;
                    state_d  = StIssue;
                    if (k_q == LAST_K) begin
                        k_d = '0;
                        q_d = q_q + 2'd1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            k_q     <= '0;
            q_q     <= '0;
            wd_q    <= '0;
            sint_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            q_q     <= q_d;
            wd_q    <= wd_d;
            sint_q  <= sint_d;
            error_q <= error_d;
        end
    end

    assign cordic_start = (state_q == StIssue);
    assign sample_valid = (state_q == StEmit);
    assign sample_idx   = i_q;
    assign sample_val   = !sample_valid ? '0 :
                          sign ? (ZERO_OFFSET - sint_q) : (ZERO_OFFSET + sint_q);
    assign busy         = state_q inside {StIssue, StWait, StEmit};
    assign frame_done   = (state_q == StDone);
    assign error        = error_q;

endmodule
